// File: rtl/ppu_stream_sink.sv
// ppu_stream_sink: FIFO-buffered PPU pixel sink with raster tracking and frame-start sync
module ppu_stream_sink #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int H_PIXELS = 32,
  parameter int V_LINES = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stb_i,
  input  logic [7:0]                   data_i,
  output logic                         ack_o,
  input  logic                         pix_en,
  output logic [7:0]                   pix_o,
  output logic                         pix_valid,
  output logic [$clog2(H_PIXELS)-1:0]  h_pos,
  output logic [$clog2(V_LINES)-1:0]   v_pos,
  output logic                         sync_o,
  output logic                         underrun,
  input  logic                         clr_underrun,
  output logic [ADDR_W:0]              level
);
  localparam int HW = $clog2(H_PIXELS);
  localparam int VW = $clog2(V_LINES);
  logic [7:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic started, accept, pop_ok, h_last, v_last, wrap;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  // Handshake/pop qualification and next raster position; the first tick after reset lands on (0,0)
  always_comb begin
    accept = stb_i && !ack_o && level != (ADDR_W+1)'(DEPTH);
    pop_ok = pix_en && level != '0;
    h_last = h_pos == HW'(H_PIXELS - 1);
    v_last = v_pos == VW'(V_LINES - 1);
    wrap = !started || (h_last && v_last);
    h_nxt = (!started || h_last) ? '0 : h_pos + HW'(1);
    v_nxt = wrap ? '0 : h_last ? v_pos + VW'(1) : v_pos;
  end
  // Byte storage; contents need no reset since the pointers define what is valid
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= data_i;
  end
  // FIFO pointers, occupancy and the one-cycle acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      ack_o <= 1'b0;
    end else begin
      ack_o <= accept;
      if (accept) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
      level <= level + (ADDR_W+1)'(accept) - (ADDR_W+1)'(pop_ok);
    end
  end
  // Pixel output and raster position advance together on each display tick, valid or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_o <= '0;
      pix_valid <= 1'b0;
      h_pos <= '0;
      v_pos <= '0;
      started <= 1'b0;
      sync_o <= 1'b0;
    end else begin
      sync_o <= pix_en && wrap;
      if (pix_en) begin
        pix_o <= pop_ok ? mem[rd_ptr] : '0;
        pix_valid <= pop_ok;
        h_pos <= h_nxt;
        v_pos <= v_nxt;
        started <= 1'b1;
      end
    end
  end
  // Sticky underrun flag; a new empty pop beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) underrun <= 1'b0;
    else underrun <= (pix_en && !pop_ok) || (underrun && !clr_underrun);
  end
endmodule

// File: tb/tb_ppu_stream_sink.sv
// tb_ppu_stream_sink: directed self-checking bench for ppu_stream_sink
module tb_ppu_stream_sink;
  logic clk = 1'b0, rst = 1'b1, stb = 1'b0, pix_en = 1'b0, clr = 1'b0;
  logic [7:0] data = '0;
  logic ack, pv, sync, urun;
  logic [7:0] pix;
  logic [4:0] h, v, level;
  int tests = 0, failed = 0;

  ppu_stream_sink dut (
    .clk(clk), .rst(rst), .stb_i(stb), .data_i(data), .ack_o(ack),
    .pix_en(pix_en), .pix_o(pix), .pix_valid(pv), .h_pos(h), .v_pos(v),
    .sync_o(sync), .underrun(urun), .clr_underrun(clr), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Upstream model: hold stb with the next byte, drop it in the ack cycle. Entered just after a negedge.
  task automatic feed(input int n, input logic [7:0] base, output int acks, output int gaps);
    int cyc, last;
    cyc = 0;
    last = -1;
    acks = 0;
    gaps = 0;
    stb = 1'b1;
    data = base;
    while (acks < n && cyc < 10 * n + 20) begin
      @(negedge clk);
      cyc++;
      if (ack) begin
        if (last >= 0 && cyc - last != 2) gaps++;
        last = cyc;
        acks++;
        stb = 1'b0;
      end else begin
        stb = acks < n;
        data = base + 8'(acks);
      end
    end
    stb = 1'b0;
  endtask

  // One display tick, then check the pixel it produced
  task automatic pop(input string tag, input logic [7:0] ep, input logic ev);
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    chk({tag, " pix"}, pix, ep);
    chk({tag, " valid"}, pv, ev);
  endtask

  initial begin
    int acks, gaps, extra, pk, pi, ph, cyc, idx, bad, sync_bad;
    logic seen;
    logic [4:0] h33, v33;
    #12;
    chk("rst ack", ack, 0);
    chk("rst pix", pix, 0);
    chk("rst valid", pv, 0);
    chk("rst pos", {h, v}, 0);
    chk("rst sync", sync, 0);
    chk("rst underrun", urun, 0);
    chk("rst level", level, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fill to full at one byte per two clocks
    feed(16, 8'h00, acks, gaps);
    chk("fill acks", acks, 16);
    chk("fill gaps", gaps, 0);
    chk("fill level", level, 16);
    stb = 1'b1;
    data = 8'hAA;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack) extra++;
    end
    chk("full no ack", extra, 0);
    chk("full level", level, 16);

    // Pop while full releases the pending 0xAA
    pop("full pop", 8'h00, 1'b1);
    chk("full pop pos", {h, v}, 0);
    chk("first sync", sync, 1);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      seen = ack;
    end
    stb = 1'b0;
    chk("pending ack", seen, 1);
    chk("refill level", level, 16);
    chk("sync one cycle", sync, 0);

    // Drain in write order, then underrun behaviour
    for (int i = 1; i < 16; i++) pop("drain", 8'(i), 1'b1);
    pop("drain aa", 8'hAA, 1'b1);
    chk("drained level", level, 0);
    chk("drained h", h, 16);
    chk("no underrun yet", urun, 0);
    pop("empty", 8'h00, 1'b0);
    chk("underrun set", urun, 1);
    chk("underrun h", h, 17);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("underrun clr", urun, 0);
    clr = 1'b1;
    pop("clr+empty", 8'h00, 1'b0);
    clr = 1'b0;
    chk("set wins", urun, 1);

    // Realign with a reset, then stream 1025 bytes with a tick every 4 clocks
    rst = 1'b1;
    @(negedge clk);
    chk("rst2 underrun", urun, 0);
    chk("rst2 pos", {h, v}, 0);
    rst = 1'b0;
    pk = 0; pi = 0; ph = 0; cyc = 0; idx = 0; bad = 0; sync_bad = 0;
    h33 = '1; v33 = '1;
    stb = 1'b1;
    data = 8'h00;
    while (pk < 1025 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (ack) begin
        idx++;
        stb = 1'b0;
      end else begin
        stb = idx < 1025;
        data = 8'(idx);
      end
      if (pix_en) begin
        if (pix !== 8'(pk) || pv !== 1'b1) bad++;
        if (sync !== (pk == 0 || pk == 1024)) sync_bad++;
        if (pk == 33) begin
          h33 = h;
          v33 = v;
        end
        pk++;
      end else if (sync) sync_bad++;
      ph = (ph + 1) % 4;
      pix_en = idx >= 8 && ph == 0 && pi < 1025;
      if (pix_en) pi++;
    end
    pix_en = 1'b0;
    stb = 1'b0;
    chk("stream count", pk, 1025);
    chk("stream order", bad, 0);
    chk("stream sync", sync_bad, 0);
    chk("pixel33 h", h33, 1);
    chk("pixel33 v", v33, 1);
    chk("frame2 pos", {h, v}, 0);
    chk("stream underrun", urun, 0);
    chk("stream level", level, 0);
    @(negedge clk);

    // Steady state at level 8: accept and pop together
    feed(8, 8'h40, acks, gaps);
    chk("pre level", level, 8);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      stb = 1'b1;
      data = 8'h48 + 8'(j);
      pix_en = 1'b1;
      @(negedge clk);
      stb = 1'b0;
      pix_en = 1'b0;
      chk("steady pix", pix, 8'h40 + 8'(j));
      chk("steady level", level, 8);
      chk("steady ack", ack, 1);
    end
    pop("tail0", 8'h48, 1'b1);
    pop("tail1", 8'h49, 1'b1);
    pop("tail2", 8'h4A, 1'b1);
    chk("pre-rst level", level, 5);

    // Asynchronous reset mid-stream, with a strobe overlapping it
    rst = 1'b1;
    stb = 1'b1;
    data = 8'h77;
    #1;
    chk("async rst level", level, 0);
    chk("async rst pix", pix, 0);
    chk("async rst valid", pv, 0);
    chk("async rst pos", {h, v}, 0);
    @(negedge clk);
    chk("rst no ack", ack, 0);
    rst = 1'b0;
    stb = 1'b0;
    pop("post rst", 8'h00, 1'b0);
    chk("post rst pos", {h, v}, 0);
    chk("post rst sync", sync, 1);
    chk("post rst level", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
